// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and window constants for the 3x3 convolution scheduler
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int WIN_SLOTS = 9;
    localparam logic [9:0] RESULT_MAX = 10'd1023;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == RESULT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// rtl/conv_line_buf.sv - shift-register line buffer whose effective length is selected at run time
module conv_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int LEN_W      = 6
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Tap the word pushed len_i transfers ago: one row back when len_i is the image width.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (len_i == LEN_W'(i + 1)) begin
                data_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/conv3x3_sched.sv
// rtl/conv3x3_sched.sv - 3x3 window scheduler feeding a convolution core; optional Err checker under CONV_SCHED_ERRCHK_EN
module conv3x3_sched
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W_MAX  = 32,
    parameter int CORE_LAT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Start,
    input  logic [5:0]                    Img_W,
    input  logic [5:0]                    Img_H,
    input  logic [DATA_WIDTH-1:0]         Pixel_In,
    input  logic                          Pixel_Valid,
    output logic                          Pixel_Ready,
    output logic [9*DATA_WIDTH-1:0]       Window_Out,
    output logic                          Core_Valid_In,
    input  logic                          Core_Valid_Out,
    output logic [9:0]                    Result_Count,
    output logic                          Busy,
    output logic                          Done
`ifdef CONV_SCHED_ERRCHK_EN
    ,
    output logic                          Err
`endif
);

    localparam logic [6:0] W_MAX      = 7'(IMG_W_MAX);
    localparam logic [7:0] DRAIN_LAST = 8'(CORE_LAT);

    state_t                state_q, state_d;
    logic [5:0]            img_w_q, img_h_q;
    logic [5:0]            col_q, row_q;
    logic                  pix_done_q;
    logic                  cvi_q;
    logic [7:0]            drain_q;
    logic [9:0]            result_q;
    logic [DATA_WIDTH-1:0] win_q [WIN_SLOTS];
    logic [DATA_WIDTH-1:0] lb1_out, lb2_out;

    logic start_ok, xfer, last_col, last_row, win_pos;

    assign start_ok = Start && (state_q == ST_IDLE) && (Img_W >= 6'd3)
                      && ({1'b0, Img_W} <= W_MAX) && (Img_H >= 6'd3);
    assign xfer     = Pixel_Valid && Pixel_Ready;
    assign last_col = (col_q == img_w_q - 6'd1);
    assign last_row = (row_q == img_h_q - 6'd1);
    assign win_pos  = (row_q >= 6'd2) && (col_q >= 6'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_FILL;
            ST_FILL:  if (xfer && row_q == 6'd2 && col_q == 6'd2) state_d = ST_RUN;
            ST_RUN:   if (cvi_q && pix_done_q) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Pixel_Ready = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !pix_done_q;
        Busy        = (state_q != ST_IDLE);
        Done        = (state_q == ST_DONE);
    end

    conv_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W_MAX), .LEN_W(6)) u_lb1 (
        .clk    (clk),
        .en_i   (xfer),
        .len_i  (img_w_q),
        .data_i (Pixel_In),
        .data_o (lb1_out)
    );

    conv_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W_MAX), .LEN_W(6)) u_lb2 (
        .clk    (clk),
        .en_i   (xfer),
        .len_i  (img_w_q),
        .data_i (lb1_out),
        .data_o (lb2_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            img_w_q    <= '0;
            img_h_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_done_q <= 1'b0;
            cvi_q      <= 1'b0;
            drain_q    <= '0;
            result_q   <= '0;
            for (int k = 0; k < WIN_SLOTS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            if (start_ok) begin
                img_w_q    <= Img_W;
                img_h_q    <= Img_H;
                col_q      <= '0;
                row_q      <= '0;
                pix_done_q <= 1'b0;
            end else if (xfer) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 6'd1;
                end else begin
                    col_q <= col_q + 6'd1;
                end
                if (last_col && last_row) pix_done_q <= 1'b1;
            end

            cvi_q   <= xfer && win_pos;
            drain_q <= (state_q == ST_DRAIN) ? drain_q + 8'd1 : 8'd0;

            if (start_ok) begin
                result_q <= '0;
            end else if (Core_Valid_Out && Busy) begin
                result_q <= sat_inc10(result_q);
            end

            // Window columns slide left; the new right column is {row r-2, row r-1, row r} at col c.
            if (xfer) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb2_out;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_out;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= Pixel_In;
            end
        end
    end

    for (genvar k = 0; k < WIN_SLOTS; k++) begin : g_win
        assign Window_Out[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
    end

    assign Core_Valid_In = cvi_q;
    assign Result_Count  = result_q;

`ifdef CONV_SCHED_ERRCHK_EN
    logic [9:0] issued_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            issued_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (cvi_q) issued_q <= sat_inc10(issued_q);
            if ((Core_Valid_Out && state_q == ST_IDLE) ||
                (state_q == ST_DONE && result_q != issued_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Err = err_q;
`endif

endmodule

// File: tb/tb_conv3x3_sched.sv
// tb/tb_conv3x3_sched.sv - scoreboard bench for conv3x3_sched with a fixed-latency core model
`timescale 1ns/1ps
module tb_conv3x3_sched;

    localparam int DW   = 32;
    localparam int WMAX = 32;
    localparam int LAT  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            Start;
    logic [5:0]      Img_W, Img_H;
    logic [DW-1:0]   Pixel_In;
    logic            Pixel_Valid;
    logic            Pixel_Ready;
    logic [9*DW-1:0] Window_Out;
    logic            Core_Valid_In;
    logic            Core_Valid_Out;
    logic [9:0]      Result_Count;
    logic            Busy;
    logic            Done;
`ifdef CONV_SCHED_ERRCHK_EN
    logic            Err;
`endif

    always #5 clk = ~clk;

    conv3x3_sched #(.DATA_WIDTH(DW), .IMG_W_MAX(WMAX), .CORE_LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .Start          (Start),
        .Img_W          (Img_W),
        .Img_H          (Img_H),
        .Pixel_In       (Pixel_In),
        .Pixel_Valid    (Pixel_Valid),
        .Pixel_Ready    (Pixel_Ready),
        .Window_Out     (Window_Out),
        .Core_Valid_In  (Core_Valid_In),
        .Core_Valid_Out (Core_Valid_Out),
        .Result_Count   (Result_Count),
        .Busy           (Busy),
        .Done           (Done)
`ifdef CONV_SCHED_ERRCHK_EN
        ,
        .Err            (Err)
`endif
    );

    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              last_cvi = 0;
    int              frame_win = 0;
    int              exp_win = 0;
    int              done_cnt = 0;
    logic [9*DW-1:0] exp_q [$];
    logic [9*DW-1:0] first_win;
    logic            pipe [0:LAT];
    logic            core_out = 1'b0;
    logic            cvo_force = 1'b0;

    assign Core_Valid_Out = core_out | cvo_force;

    initial for (int i = 0; i <= LAT; i++) pipe[i] = 1'b0;

    task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fp32(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    // Monitor: core latency model plus scoreboard pop on every issued window.
    always @(negedge clk) begin
        logic [9*DW-1:0] e;
        cyc++;
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]  = Core_Valid_In;
        core_out = pipe[LAT];
        if (Core_Valid_In) begin
            if (frame_win == 0) first_win = Window_Out;
            frame_win++;
            last_cvi = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_window", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("window", Window_Out, e);
            end
        end
        if (Done) begin
            done_cnt++;
            check("done_latency", cyc - last_cvi, LAT + 2);
            check("result_count", Result_Count, exp_win);
        end
    end

    task automatic run_frame(input int w, input int h, input int base, input bit gaps,
                             input int start_at, input int rst_at, input bit chk_first);
        int idx, budget, r, c, d0, k;
        logic [9*DW-1:0] ew;
        int hand [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        idx = 0;
        budget = 0;
        frame_win = 0;
        exp_win = (w - 2) * (h - 2);
        d0 = done_cnt;
        @(negedge clk);
        Start = 1'b1; Img_W = 6'(w); Img_H = 6'(h);
        @(negedge clk);
        Start = 1'b0;
        check("start_busy", Busy, 1);
        check("start_rc_clear", Result_Count, 0);
        while (idx < w * h && budget < 5000) begin
            budget++;
            Pixel_Valid = gaps ? ((budget % 2) == 0) : 1'b1;
            Pixel_In    = fp32(base + idx);
            Start       = (idx == start_at);
            if (Start) begin
                Img_W = 6'd3; Img_H = 6'd3;
            end
            if (idx == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; Pixel_Valid = 1'b0;
                check("rst_busy", Busy, 0);
                check("rst_ready", Pixel_Ready, 0);
                check("rst_cvi", Core_Valid_In, 0);
                check("rst_done", Done, 0);
                check("rst_rc", Result_Count, 0);
                check("rst_window", Window_Out, 0);
                repeat (LAT + 8) @(negedge clk);
                check("rst_no_done", done_cnt, d0);
                return;
            end
            if (Pixel_Valid && Pixel_Ready) begin
                r = idx / w;
                c = idx % w;
                if (r >= 2 && c >= 2) begin
                    for (int s = 0; s < 9; s++)
                        ew[s*DW +: DW] = fp32(base + (r - 2 + s / 3) * w + (c - 2 + s % 3));
                    exp_q.push_back(ew);
                end
                idx++;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        Pixel_Valid = 1'b0;
        check("pixel_budget", idx, w * h);
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_cnt, d0 + 1);
        @(negedge clk);
        check("done_pulse", Done, 0);
        check("busy_after", Busy, 0);
        check("win_count", frame_win, exp_win);
        check("queue_empty", exp_q.size(), 0);
        if (chk_first) begin
            for (int s = 0; s < 9; s++) ew[s*DW +: DW] = fp32(hand[s]);
            check("first_window", first_win, ew);
        end
    endtask

    task automatic bad_start(input int w, input int h);
        @(negedge clk);
        Start = 1'b1; Img_W = 6'(w); Img_H = 6'(h);
        @(negedge clk);
        Start = 1'b0;
        check("bad_start_busy", Busy, 0);
        check("bad_start_ready", Pixel_Ready, 0);
        repeat (2) @(negedge clk);
        check("bad_start_idle", Busy, 0);
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; Img_W = '0; Img_H = '0;
        Pixel_In = '0; Pixel_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", Busy, 0);
        check("reset_ready", Pixel_Ready, 0);
        check("reset_cvi", Core_Valid_In, 0);
        check("reset_done", Done, 0);
        check("reset_rc", Result_Count, 0);
        check("reset_window", Window_Out, 0);
`ifdef CONV_SCHED_ERRCHK_EN
        check("reset_err", Err, 0);
`endif
        rst = 1'b0;

        run_frame(4, 4, 1, 1'b0, -1, -1, 1'b1);
        run_frame(4, 4, 1, 1'b1, -1, -1, 1'b1);
        bad_start(2, 4);
        bad_start(4, 2);
        bad_start(33, 3);
        run_frame(WMAX, 3, 1, 1'b0, -1, -1, 1'b0);
        run_frame(4, 4, 1, 1'b0, 12, -1, 1'b0);
        run_frame(4, 4, 1, 1'b0, -1, 6, 1'b0);
        run_frame(3, 3, 50, 1'b0, -1, -1, 1'b0);

`ifdef CONV_SCHED_ERRCHK_EN
        @(negedge clk);
        cvo_force = 1'b1;
        @(negedge clk);
        cvo_force = 1'b0;
        check("err_set", Err, 1);
        repeat (3) @(negedge clk);
        check("err_sticky", Err, 1);
        run_frame(3, 3, 20, 1'b0, -1, -1, 1'b0);
        check("err_cleared", Err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
